// File: rtl/rr_grant_pkg.sv
// Shared types and sizes for the round-robin grant scheduler.
package rr_grant_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/dec3to8_en.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module dec3to8_en
  import rr_grant_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_sched.sv
// Round-robin scheduler: grants one of eight requesters through a shared
// 3-to-8 decoder and holds the grant until release or hold timeout.
module rr_grant_sched
  import rr_grant_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int unsigned CNT_W     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam bit          HOLD_EN   = (MAX_HOLD != 0);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic             release_c;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    dbl = {r, r};
    rot = N_REQ'(dbl >> p);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    return IDX_W'(p + off);
  endfunction

  assign release_c = done || !req[grant_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
      timeout     <= timeout_nxt;
      hold_cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = grant_idx;
    valid_nxt   = grant_valid;
    timeout_nxt = 1'b0;
    cnt_nxt     = hold_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          idx_nxt   = rr_pick(req, ptr);
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        // A release in the same cycle as the hold limit wins, so no timeout pulse.
        if (release_c) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          ptr_nxt   = IDX_W'(grant_idx + 1'b1);
        end else if (HOLD_EN && (hold_cnt == CNT_W'(HOLD_LAST))) begin
          state_nxt   = IDLE;
          valid_nxt   = 1'b0;
          timeout_nxt = 1'b1;
          ptr_nxt     = IDX_W'(grant_idx + 1'b1);
        end else if (hold_cnt != {CNT_W{1'b1}}) begin
          cnt_nxt = CNT_W'(hold_cnt + 1'b1);
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  dec3to8_en u_dec (
    .idx (grant_idx),
    .en  (grant_valid),
    .y   (grant)
  );

endmodule
